// File: rtl/simd_mac_sequencer.sv
// Element sequencer for a SIMD multiply-accumulate reduction: it counts accepted
// multiply-unit results, feeds the running value back, and presents the final one.
module simd_mac_sequencer #(
  parameter int BIT_WIDTH = 32,
  parameter int LEN_BITS  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        flush,
  input  logic [LEN_BITS-1:0]         vec_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] mul_data,
  output logic signed [BIT_WIDTH-1:0] data_acc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic                        sat_flag,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic signed [BIT_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_BITS-1:0]         count_q, count_d;
  logic [LEN_BITS-1:0]         len_q, len_d;
  logic                        sat_q, sat_d;
  logic                        done_q, done_d;

  // The multiply unit clamps to either rail, so hitting one means saturation occurred.
  function automatic logic is_sat_val(input logic signed [BIT_WIDTH-1:0] v);
    return (v == {1'b0, {(BIT_WIDTH-1){1'b1}}}) ||
           (v == {1'b1, {(BIT_WIDTH-1){1'b0}}});
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      len_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
            len_d   = vec_len;
            state_d = (vec_len == '0) ? OUTPUT : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            // The multiply unit already folded in the accumulator; just take its result.
            acc_d   = mul_data;
            count_d = count_q + LEN_BITS'(1);
            sat_d   = sat_q | is_sat_val(mul_data);
            if (count_q == len_q - LEN_BITS'(1)) begin
              state_d = OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign out_data  = out_valid ? acc_q : '0;
  assign data_acc  = acc_q;
  assign sat_flag  = sat_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: doc/simd_mac_sequencer.md
SIMD_MAC_SEQUENCER -- requirements
Module: simd_mac_sequencer

Interface
REQ-001 The module SHALL have parameter BIT_WIDTH, default 32, the element/accumulator width matching the SIMD multiply unit.
REQ-002 The module SHALL have parameter LEN_BITS, default 16, the width of the vector-length field and element counter.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a MAC reduction; honoured only in IDLE.
REQ-007 flush  input  1  synchronous abort; returns to IDLE and clears state.
REQ-008 vec_len  input  LEN_BITS  number of elements to reduce; sampled on an accepted start.
REQ-009 in_valid  input  1  mul_data holds a valid multiply-unit result (MAC function) for the current element.
REQ-010 in_ready  output  1  sequencer accepts mul_data this cycle.
REQ-011 mul_data  input  signed BIT_WIDTH  saturated product-plus-accumulator from the multiply unit.
REQ-012 data_acc  output  signed BIT_WIDTH  running accumulator fed back to the multiply unit's accumulator operand.
REQ-013 out_valid  output  1  out_data holds the final reduction result.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 out_data  output  signed BIT_WIDTH  final accumulated value.
REQ-016 sat_flag  output  1  sticky; some accepted mul_data in this reduction equalled the max-positive or max-negative value.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse in the cycle after the result is taken.

Function
REQ-019 States SHALL be IDLE, ACCUM and OUTPUT, encoded in a registered state variable.
REQ-020 In IDLE, start=1 with vec_len>0 SHALL clear acc, count and sat_flag and enter ACCUM next cycle.
REQ-021 In IDLE, start=1 with vec_len=0 SHALL clear acc and sat_flag and enter OUTPUT directly, so out_data=0.
REQ-022 start outside IDLE SHALL be ignored, with no effect on state, count or acc.
REQ-023 in_ready SHALL be 1 only in ACCUM and 0 in all other states.
REQ-024 A beat transfers when in_valid=1 and in_ready=1; acc SHALL load mul_data, count SHALL increment, and sat_flag SHALL set if mul_data is {0,1...1} or {1,0...0}.
REQ-025 No addition is performed in this block; saturation of the sum is the multiply unit's responsibility.
REQ-026 in_valid=0 in ACCUM SHALL hold acc, count and state unchanged, for any number of stall cycles.
REQ-027 On the transfer with count = vec_len-1, state SHALL move to OUTPUT, and out_valid SHALL be high the next cycle with out_data equal to the last accepted mul_data.
REQ-028 Latency from the last accepted beat to out_valid SHALL be 1 cycle.
REQ-029 data_acc SHALL equal the acc register at all times; it is 0 during the first element's cycle.
REQ-030 In OUTPUT, out_valid and out_data SHALL hold stable until out_ready=1, then state SHALL go to IDLE and done SHALL pulse 1 the next cycle.
REQ-031 count SHALL be LEN_BITS wide; vec_len = 2^LEN_BITS-1 SHALL complete without wrap.
REQ-032 flush=1 SHALL have priority over start, transfers and out_ready: next cycle state=IDLE, acc=0, count=0, sat_flag=0, out_valid=0, done=0.
REQ-033 sat_flag SHALL remain valid through OUTPUT and until the next accepted start or flush.

Reset
REQ-034 While reset=0, state SHALL be IDLE and acc, count, data_acc, out_data, out_valid, in_ready, sat_flag, busy and done SHALL all be 0, independent of clk.
REQ-035 Reset asserted mid-reduction SHALL discard all progress; no out_valid or done follows reset release without a new start.

Verification
REQ-036 start, vec_len=3, then mul_data 5, 12, 20 on consecutive valid cycles -> out_valid one cycle after the third beat, out_data=20, sat_flag=0, done after out_ready.
REQ-037 vec_len=4 with in_valid gaps of 2 cycles between beats -> count advances only on transfers, and data_acc tracks the last beat throughout.
REQ-038 start with vec_len=0 -> OUTPUT next cycle, out_data=0, in_ready never asserted.
REQ-039 Result ready with out_ready held 0 for 5 cycles, plus a start pulse in that window -> out_data stable, start ignored, a single done pulse.
REQ-040 Beat mul_data=0x7FFFFFFF inside a 3-element reduction -> sat_flag=1 until the next start.
REQ-041 flush, or reset=0, after 2 of 6 beats -> IDLE with all outputs 0, and a following start with vec_len=1 and mul_data=9 gives out_data=9.
